elink_trig_unroller_param: RTL and testbench

//  Parametrised successor to the fixed 8-bit trigger e-link unroller; sits after elink word alignment, before trigger-cell (TC) routing.
//  - Hunts for a frame header on the e-link byte/word stream.
//  - Accumulates the full frame, then unrolls it into N_TC tagged words, one per cycle, with an explicit valid strobe.
//  - Double-buffered: the next frame is captured while the previous one drains.
//  - Adds input qualification, overflow reporting and a frame counter.

---
 rtl/elink_trig_unroller_param.sv | 182 ++++++++++++++++++
 tb/tb_elink_trig_unroller_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elink_trig_unroller_param.sv
// -----------------------------------------------------------------------------
// elink_trig_unroller_param
//
// Purpose:
//   Trigger e-link unroller placed after word alignment and before trigger-cell
//   routing. It hunts for a frame header in the qualified beat stream, collects
//   one full frame of N_TC trigger-cell payloads, then presents the payloads
//   as tagged words, one per cycle. Capture and drain are double-buffered, so
//   the next frame is collected while the previous one is still being sent.
//
// Ports:
//   clk             in   1       clock
//   reset           in   1       asynchronous, active-low reset
//   data_in         in   LINK_W  aligned e-link beat
//   data_in_valid   in   1       beat qualifier; unqualified beats are ignored
//   data_out        out  OUT_W   {1'b1, tc index, tc payload}
//   data_out_valid  out  1       data_out carries a new word this cycle
//   frame_done      out  1       one-cycle pulse after the last beat of a frame
//   overflow        out  1       one-cycle pulse when a frame replaced a drain
//                                that still had words left
//   frame_count     out  16      completed frames, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module elink_trig_unroller_param #(
  parameter int              LINK_W = 8,
  parameter int              HDR_W  = 4,
  parameter logic [HDR_W-1:0] HDR   = 4'b1010,
  parameter int              TC_W   = 7,
  parameter int              N_TC   = 4,
  parameter int              IDX_W  = 2,
  localparam int             OUT_W  = 1 + IDX_W + TC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LINK_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_out_valid,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  localparam int PAY_W      = N_TC * TC_W;
  localparam int BEATS      = (HDR_W + PAY_W) / LINK_W;
  localparam int HEAD_PAY_W = LINK_W - HDR_W;
  localparam int BCNT_W     = $clog2(BEATS + 1);

  // Parameter legality is checked at elaboration.
  generate
    if (((HDR_W + PAY_W) % LINK_W) != 0) begin : g_bad_frame_len
      $error("elink_trig_unroller_param: HDR_W + N_TC*TC_W must be a multiple of LINK_W");
    end
    if (HDR_W >= LINK_W) begin : g_bad_hdr_w
      $error("elink_trig_unroller_param: HDR_W must be smaller than LINK_W");
    end
    if (N_TC < 2) begin : g_bad_n_tc
      $error("elink_trig_unroller_param: N_TC must be at least 2");
    end
    if (IDX_W != $clog2(N_TC)) begin : g_bad_idx_w
      $error("elink_trig_unroller_param: IDX_W must equal clog2(N_TC)");
    end
  endgenerate

  typedef enum logic {
    S_HUNT    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  // Capture side
  state_t            r_state;
  state_t            w_state_next;
  logic [BCNT_W-1:0] r_beat;
  logic [BCNT_W-1:0] w_beat_next;
  logic [PAY_W-1:0]  r_acc;
  logic [PAY_W-1:0]  w_acc_next;
  logic              w_complete;
  logic              w_hdr_hit;
  int                w_base;

  // Drain side
  logic [PAY_W-1:0]  r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic              r_active;   // a word from r_buf is due in the next cycle
  logic [TC_W-1:0]   w_tc [N_TC];
  logic [TC_W-1:0]   w_new_tc0;

  assign w_hdr_hit = (data_in[LINK_W-1 -: HDR_W] == HDR);

  // Beat b (b >= 1) lands right below the header-beat payload bits, MSB-first.
  assign w_base = PAY_W - 1 - HEAD_PAY_W - (int'(r_beat) - 1) * LINK_W;

  // Capture FSM: next-state, beat count and payload placement.
  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    w_acc_next   = r_acc;
    w_complete   = 1'b0;
    if (data_in_valid) begin
      case (r_state)
        S_HUNT: begin
          if (w_hdr_hit) begin
            w_acc_next                          = '0;
            w_acc_next[PAY_W-1 -: HEAD_PAY_W]   = data_in[HEAD_PAY_W-1:0];
            w_beat_next                         = BCNT_W'(1);
            if (BEATS == 1) begin
              w_complete = 1'b1;
            end else begin
              w_state_next = S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          // Header-looking beats here are plain payload.
          w_acc_next[w_base -: LINK_W] = data_in;
          w_beat_next                  = r_beat + BCNT_W'(1);
          if (r_beat == BCNT_W'(BEATS - 1)) begin
            w_complete   = 1'b1;
            w_state_next = S_HUNT;
          end
        end
        default: begin
          w_state_next = S_HUNT;
        end
      endcase
    end
  end

  // TC k sits at the k-th TC_W slice counted from the payload MSB.
  genvar gi;
  generate
    for (gi = 0; gi < N_TC; gi++) begin : g_tc_slice
      assign w_tc[gi] = r_buf[PAY_W-1-gi*TC_W -: TC_W];
    end
  endgenerate

  assign w_new_tc0 = w_acc_next[PAY_W-1 -: TC_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_HUNT;
      r_beat         <= '0;
      r_acc          <= '0;
      r_buf          <= '0;
      r_idx          <= '0;
      r_active       <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      frame_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat     <= w_beat_next;
      r_acc      <= w_acc_next;
      frame_done <= w_complete;
      // The word already on data_out this cycle was delivered; anything still
      // pending in the old buffer is discarded.
      overflow   <= w_complete & r_active;

      if (w_complete) begin
        // New frame goes straight out: TC0 now, the rest from r_buf.
        frame_count    <= frame_count + 16'd1;
        r_buf          <= w_acc_next;
        data_out       <= {1'b1, {IDX_W{1'b0}}, w_new_tc0};
        data_out_valid <= 1'b1;
        r_idx          <= IDX_W'(1);
        r_active       <= 1'b1;
      end else if (r_active) begin
        data_out       <= {1'b1, r_idx, w_tc[r_idx]};
        data_out_valid <= 1'b1;
        r_idx          <= r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(N_TC - 1)) begin
          r_active <= 1'b0;
        end
      end else begin
        // data_out deliberately holds its last word.
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_elink_trig_unroller_param.sv
// -----------------------------------------------------------------------------
// tb_elink_trig_unroller_param
//
// Purpose:
//   Self-checking bench. Two instances are exercised: the default 8-bit link
//   and a 32-bit link where each beat is a full frame. A bit-queue reference
//   model predicts every output word with its cycle, frame_done/frame_count
//   and overflow pulses; a monitor compares the DUT outputs against those
//   predictions every cycle.
// -----------------------------------------------------------------------------
module tb_elink_trig_unroller_param;

  localparam int OUT_W = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din0;
  logic        vin0;
  logic [9:0]  dout0;
  logic        dv0, fd0, ov0;
  logic [15:0] fc0;
  logic [31:0] din1;
  logic        vin1;
  logic [9:0]  dout1;
  logic        dv1, fd1, ov1;
  logic [15:0] fc1;

  always #5 clk = ~clk;

  elink_trig_unroller_param dut0 (
    .clk(clk), .reset(reset), .data_in(din0), .data_in_valid(vin0),
    .data_out(dout0), .data_out_valid(dv0), .frame_done(fd0),
    .overflow(ov0), .frame_count(fc0)
  );

  elink_trig_unroller_param #(.LINK_W(32)) dut1 (
    .clk(clk), .reset(reset), .data_in(din1), .data_in_valid(vin1),
    .data_out(dout1), .data_out_valid(dv1), .frame_done(fd1),
    .overflow(ov1), .frame_count(fc1)
  );

  typedef struct { int cyc; logic [9:0] word; } wexp_t;
  typedef struct { int cyc; logic [15:0] cnt; } dexp_t;

  wexp_t       wq [2][$];
  dexp_t       dq [2][$];
  int          oq [2][$];
  bit          bits [2][$];
  bit          in_frame [2];
  logic [15:0] mcount [2];
  logic [9:0]  last_word [2];
  logic [9:0]  seen [2][$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wq[d].delete(); dq[d].delete(); oq[d].delete(); bits[d].delete();
      in_frame[d] = 0; mcount[d] = 16'd0; last_word[d] = 10'd0;
    end
  endtask

  // Frame completed by the beat sampled at edge e.
  task automatic model_complete(input int d, input int e);
    int lost;
    int tc;
    mcount[d] = mcount[d] + 16'd1;
    dq[d].push_back('{e, mcount[d]});
    lost = 0;
    while (wq[d].size() > 0 && wq[d][wq[d].size()-1].cyc >= e) begin
      void'(wq[d].pop_back());
      lost++;
    end
    if (lost > 0) oq[d].push_back(e);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kk;
      tc = 0;
      for (int b = 0; b < 7; b++) tc = (tc << 1) | int'(bits[d][k*7+b]);
      kk = 2'(k);
      wq[d].push_back('{e + k, {1'b1, kk, 7'(tc)}});
    end
  endtask

  task automatic model_beat(input int d, input int lw, input logic [31:0] v);
    if (!in_frame[d]) begin
      if (((v >> (lw - 4)) & 32'hF) == 32'hA) begin
        in_frame[d] = 1;
        bits[d].delete();
        for (int i = lw - 5; i >= 0; i--) bits[d].push_back(v[i]);
      end
    end else begin
      for (int i = lw - 1; i >= 0; i--) bits[d].push_back(v[i]);
    end
    if (in_frame[d] && bits[d].size() == 28) begin
      model_complete(d, cyc + 1);
      in_frame[d] = 0;
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_one(input int d, input logic dv, input logic [9:0] dout,
                             input logic fd, input logic ov, input logic [15:0] fc);
    wexp_t w;
    bit    expd, expo;
    if (dv) begin
      if (wq[d].size() == 0) begin
        chk($sformatf("dut%0d unexpected word", d), {22'd0, dout}, 32'hFFFF_FFFF);
      end else begin
        w = wq[d].pop_front();
        chk($sformatf("dut%0d word cycle", d), cyc, w.cyc);
        chk($sformatf("dut%0d data_out", d), {22'd0, dout}, {22'd0, w.word});
        last_word[d] = w.word;
        seen[d].push_back(dout);
      end
    end else begin
      if (wq[d].size() > 0 && wq[d][0].cyc <= cyc) begin
        w = wq[d].pop_front();
        chk($sformatf("dut%0d missing word", d), {31'd0, dv}, 32'd1);
      end
      chk($sformatf("dut%0d hold data_out", d), {22'd0, dout}, {22'd0, last_word[d]});
    end
    expd = (dq[d].size() > 0 && dq[d][0].cyc == cyc);
    chk($sformatf("dut%0d frame_done", d), {31'd0, fd}, {31'd0, expd});
    if (expd) begin
      chk($sformatf("dut%0d frame_count", d), {16'd0, fc}, {16'd0, dq[d][0].cnt});
      void'(dq[d].pop_front());
    end
    expo = (oq[d].size() > 0 && oq[d][0] == cyc);
    chk($sformatf("dut%0d overflow", d), {31'd0, ov}, {31'd0, expo});
    if (expo) void'(oq[d].pop_front());
  endtask

  always @(posedge clk) begin
    #1;
    if (reset) begin
      monitor_one(0, dv0, dout0, fd0, ov0, fc0);
      monitor_one(1, dv1, dout1, fd1, ov1, fc1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v0, input logic [7:0] d0, input bit v1, input logic [31:0] d1);
    @(negedge clk);
    vin0 = v0; din0 = d0; vin1 = v1; din1 = d1;
    if (v0) model_beat(0, 8, {24'd0, d0});
    if (v1) model_beat(1, 32, d1);
    $display("cycle %0d: dut0 v=%0d d=%02h | dut1 v=%0d d=%08h", cyc + 1, v0, d0, v1, d1);
  endtask

  task automatic beat0(input logic [7:0] d0);
    step(1'b1, d0, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 32'd0);
  endtask

  task automatic chk_seen0_t1(input string tag);
    logic [9:0] t1w [4];
    t1w = '{10'h22D, 10'h2DB, 10'h30F, 10'h3D8};
    chk({tag, " word count"}, seen[0].size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen[0].size()) chk($sformatf("%s word %0d", tag, i), {22'd0, seen[0][i]}, {22'd0, t1w[i]});
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " dut0 data_out"}, {22'd0, dout0}, 32'd0);
    chk({tag, " dut0 valid/done/ovf"}, {29'd0, dv0, fd0, ov0}, 32'd0);
    chk({tag, " dut0 frame_count"}, {16'd0, fc0}, 32'd0);
    chk({tag, " dut1 frame_count"}, {16'd0, fc1}, 32'd0);
  endtask

  initial begin
    logic [9:0] t6w [5];
    t6w = '{10'h200, 10'h200, 10'h280, 10'h300, 10'h382};
    reset = 1'b1; vin0 = 1'b0; din0 = '0; vin1 = 1'b0; din1 = '0;
    model_reset();
    #2 reset = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: single frame
    seen[0].delete();
    beat0(8'hA5); beat0(8'hB6); beat0(8'hC7); beat0(8'hD8);
    idle(6);
    chk_seen0_t1("t1");
    chk("t1 frame_count", {16'd0, fc0}, 32'd1);

    // 2: non-header beats dropped, header value inside a frame is payload
    seen[0].delete();
    beat0(8'h55); beat0(8'hFF); beat0(8'h5A);
    idle(3);
    chk("t2 no words in hunt", seen[0].size(), 0);
    beat0(8'hA5); beat0(8'hA0); beat0(8'h12); beat0(8'h34);
    idle(6);
    chk("t2 word count", seen[0].size(), 4);

    // 3: invalid gap mid-frame
    seen[0].delete();
    beat0(8'hA5); beat0(8'hB6); idle(3); beat0(8'hC7); beat0(8'hD8);
    idle(6);
    chk_seen0_t1("t3");

    // 4: back-to-back frames drain without gaps
    seen[0].delete();
    beat0(8'hA5); beat0(8'hB6); beat0(8'hC7); beat0(8'hD8);
    beat0(8'hA1); beat0(8'h23); beat0(8'h45); beat0(8'h67);
    idle(6);
    chk("t4 word count", seen[0].size(), 8);

    // 5: reset mid-frame
    beat0(8'hA5); beat0(8'hB6);
    @(negedge clk);
    vin0 = 1'b0;
    reset = 1'b0;
    model_reset();
    #1 chk_outputs_zero("t5 reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen[0].delete();
    beat0(8'hA5); beat0(8'hB6); beat0(8'hC7); beat0(8'hD8);
    idle(6);
    chk_seen0_t1("t5");
    chk("t5 frame_count", {16'd0, fc0}, 32'd1);

    // 6: one-beat frames on a 32-bit link overflow the drain
    seen[1].delete();
    step(1'b0, 8'd0, 1'b1, 32'hA000_0001);
    step(1'b0, 8'd0, 1'b1, 32'hA000_0002);
    idle(6);
    chk("t6 word count", seen[1].size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seen[1].size()) chk($sformatf("t6 word %0d", i), {22'd0, seen[1][i]}, {22'd0, t6w[i]});
    chk("t6 frame_count", {16'd0, fc1}, 32'd2);

    // Randomized traffic on both links
    for (int i = 0; i < 1500; i++) begin
      logic [7:0]  d0;
      logic [31:0] d1;
      d0 = ($urandom_range(0, 2) == 0) ? {4'hA, 4'($urandom)} : 8'($urandom);
      d1 = ($urandom_range(0, 1) == 0) ? {4'hA, 28'($urandom)} : $urandom;
      step($urandom_range(0, 3) != 0, d0, $urandom_range(0, 2) == 0, d1);
    end
    idle(8);
    chk("dut0 words drained", wq[0].size(), 0);
    chk("dut1 words drained", wq[1].size(), 0);
    chk("dut0 done drained", dq[0].size(), 0);
    chk("dut1 done drained", dq[1].size(), 0);
    chk("dut1 frame_count final", {16'd0, fc1}, {16'd0, mcount[1]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
